// File: rtl/mm_mac_scheduler.sv
// Unsigned N x N matrix multiply C = A x B computed on one shared multiply-accumulate unit.
// Operands are written while idle; results come back through a registered read port.
module mm_mac_scheduler #(
    parameter int DW   = 8,
    parameter int N    = 2,
    parameter int ACCW = 2*DW+2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [3:0]      wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [3:0]      rd_addr,
    output logic [ACCW-1:0] rd_data
);

    localparam int         NN  = N*N;
    localparam logic [3:0] N4  = 4'(N);
    localparam logic [1:0] NM1 = 2'(N-1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    // Banks are sized for the largest supported N so any 4-bit address indexes them safely.
    logic [DW-1:0]   a_mem [16];
    logic [DW-1:0]   b_mem [16];
    logic [ACCW-1:0] c_mem [16];

    state_t          state_reg;
    logic [1:0]      i_reg, j_reg, k_reg;
    logic [ACCW-1:0] acc_reg;
    logic            busy_reg, done_reg;
    logic [ACCW-1:0] rd_data_reg;

    logic [3:0]      a_idx, b_idx, c_idx;
    logic [ACCW-1:0] prod_next;
    logic            wr_ok, rd_ok;

    always_comb begin
        a_idx     = {2'b00, i_reg} * N4 + {2'b00, k_reg};
        b_idx     = {2'b00, k_reg} * N4 + {2'b00, j_reg};
        c_idx     = {2'b00, i_reg} * N4 + {2'b00, j_reg};
        prod_next = ACCW'(a_mem[a_idx]) * ACCW'(b_mem[b_idx]);
        wr_ok     = {1'b0, wr_addr} < 5'(NN);
        rd_ok     = {1'b0, rd_addr} < 5'(NN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            acc_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_data_reg <= '0;
            a_mem       <= '{default: '0};
            b_mem       <= '{default: '0};
            c_mem       <= '{default: '0};
        end else begin
            done_reg    <= 1'b0;
            rd_data_reg <= rd_ok ? c_mem[rd_addr] : '0;
            case (state_reg)
                IDLE: begin
                    // A write in the start cycle lands before the first MAC cycle reads the banks.
                    if (wr_en && wr_ok) begin
                        if (wr_sel) b_mem[wr_addr] <= wr_data;
                        else        a_mem[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        state_reg <= MAC;
                        busy_reg  <= 1'b1;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        acc_reg   <= '0;
                    end
                end
                MAC: begin
                    if (k_reg == NM1) begin
                        c_mem[c_idx] <= acc_reg + prod_next;
                        acc_reg      <= '0;
                        k_reg        <= '0;
                        if (j_reg == NM1) begin
                            j_reg <= '0;
                            if (i_reg == NM1) begin
                                i_reg     <= '0;
                                state_reg <= DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                i_reg <= i_reg + 2'd1;
                            end
                        end else begin
                            j_reg <= j_reg + 2'd1;
                        end
                    end else begin
                        acc_reg <= acc_reg + prod_next;
                        k_reg   <= k_reg + 2'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_mm_mac_scheduler.sv
// Directed bench for mm_mac_scheduler (N=2, DW=8): handshake timing, results, lockout, reset abort, bounds.
module tb_mm_mac_scheduler;

    localparam int DW   = 8;
    localparam int N    = 2;
    localparam int ACCW = 2*DW+2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en;
    logic            wr_sel;
    logic [3:0]      wr_addr;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic [3:0]      rd_addr;
    logic [ACCW-1:0] rd_data;

    int err_cnt = 0;
    int chk_cnt = 0;

    mm_mac_scheduler #(.DW(DW), .N(N), .ACCW(ACCW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load(input logic sel, input logic [7:0] v0, input logic [7:0] v1,
                        input logic [7:0] v2, input logic [7:0] v3);
        wr(sel, 4'd0, v0);
        wr(sel, 4'd1, v1);
        wr(sel, 4'd2, v2);
        wr(sel, 4'd3, v3);
    endtask

    task automatic read_c(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        @(posedge clk); #1;
        check(tag, 32'(rd_data), exp);
    endtask

    task automatic read_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        read_c({tag, "_c0"}, 4'd0, e0);
        read_c({tag, "_c1"}, 4'd1, e1);
        read_c({tag, "_c2"}, 4'd2, e2);
        read_c({tag, "_c3"}, 4'd3, e3);
    endtask

    // mode 0: plain run; 1: writes/starts during busy; 2: reset on 4th MAC cycle.
    // pre_wr: write A[pa]=pd in the same cycle as start.
    task automatic run(input string tag, input int mode, input logic pre_wr,
                       input logic [3:0] pa, input logic [7:0] pd);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        int last_busy = 0;
        int both_hi  = 0;
        start = 1'b1;
        if (pre_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = pa; wr_data = pd;
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (busy) begin busy_cnt++; last_busy = n; end
            if (done) begin done_cnt++; if (done_at == 0) done_at = n; end
            if (busy && done) both_hi++;
            if (mode == 1) begin
                start = (n == 2) || (n == 4);
                wr_en = (n == 2); wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd9;
            end
            if (mode == 2) rst_n = !(n == 4);
            @(posedge clk); #1;
        end
        start = 1'b0; wr_en = 1'b0; rst_n = 1'b1;
        if (mode == 2) begin
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
            check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
        end else begin
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
            check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
            check({tag, "_done_at"}, 32'(done_at), 32'd9);
            check({tag, "_busy_fall"}, 32'(last_busy + 1), 32'(done_at));
            check({tag, "_overlap"}, 32'(both_hi), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        read_c("rst_c0", 4'd0, 32'd0);

        // 1. identity
        load(1'b0, 8'd1, 8'd0, 8'd0, 8'd1);
        load(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        run("ident", 0, 1'b0, 4'd0, 8'd0);
        read_all("ident", 32'd5, 32'd6, 32'd7, 32'd8);

        // 2. general
        load(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        run("gen", 0, 1'b0, 4'd0, 8'd0);
        read_all("gen", 32'd19, 32'd22, 32'd43, 32'd50);

        // 3. max values
        load(1'b0, 8'd255, 8'd255, 8'd255, 8'd255);
        load(1'b1, 8'd255, 8'd255, 8'd255, 8'd255);
        run("max", 0, 1'b0, 4'd0, 8'd0);
        read_all("max", 32'd130050, 32'd130050, 32'd130050, 32'd130050);

        // 4. busy lockout
        load(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        load(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        run("lock", 1, 1'b0, 4'd0, 8'd0);
        read_all("lock", 32'd19, 32'd22, 32'd43, 32'd50);
        run("rerun", 0, 1'b0, 4'd0, 8'd0);
        read_all("rerun", 32'd19, 32'd22, 32'd43, 32'd50);

        // 5. reset mid-operation
        run("abort", 2, 1'b0, 4'd0, 8'd0);
        read_all("abort", 32'd0, 32'd0, 32'd0, 32'd0);
        load(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        load(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        run("post", 0, 1'b0, 4'd0, 8'd0);
        read_all("post", 32'd19, 32'd22, 32'd43, 32'd50);

        // 6. address bounds and same-cycle write+start
        wr(1'b0, 4'd7, 8'hAA);
        read_c("oob_rd5", 4'd5, 32'd0);
        run("oob", 0, 1'b0, 4'd0, 8'd0);
        read_all("oob", 32'd19, 32'd22, 32'd43, 32'd50);
        run("same", 0, 1'b1, 4'd3, 8'd10);
        read_all("same", 32'd19, 32'd22, 32'd85, 32'd98);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
